// File: rtl/bsg_arb_rr_one_hot_buffered.sv
// bsg_arb_rr_one_hot_buffered
//   Round-robin arbiter with a single-entry registered output buffer.
//   The one-hot grant drives the mux select and the requester yumi.
//   The granted word, its one-hot source tag and a valid flag are presented downstream
//   on a valid/ready handshake.
//   Optional feature macro: BSG_ARB_RR_LOCK_EN adds lock_i, which lets the last
//   granted requester keep the channel while it still requests.
module bsg_arb_rr_one_hot_buffered #(
  parameter int width_p = 32,
  parameter int els_p   = 5
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   data_i,
  output logic [els_p-1:0]           yumi_o,
  output logic [els_p-1:0]           sel_one_hot_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [els_p-1:0]           tag_o,
  input  logic                       ready_i
`ifdef BSG_ARB_RR_LOCK_EN
  ,
  input  logic                       lock_i
`endif
);

  localparam logic [els_p-1:0] one_lp = els_p'(1);

  // Buffer and priority state
  logic                 v_q, v_d;
  logic [width_p-1:0]   data_q, data_d;
  logic [els_p-1:0]     tag_q, tag_d;
  logic [els_p-1:0]     last_q, last_d;

  // Arbitration intermediates
  logic                 accept;
  logic [els_p-1:0]     hi_mask;
  logic [els_p-1:0]     hi_req;
  logic [els_p-1:0]     rr_pick;
  logic [els_p-1:0]     pick;
  logic [els_p-1:0]     grant;
  logic [width_p-1:0]   data_sel;
  logic [width_p-1:0]   masked_words [els_p];

  // A draining full buffer can take a new word in the same cycle.
  assign accept = (|v_i) & (~v_q | ready_i) & reset_n_i;

  // Requesters strictly above last_q.  When last_q is the top bit the shift
  // overflows to zero, the subtraction yields all ones and the mask is empty,
  // so the scan wraps naturally to the low-order requesters.
  assign hi_mask = ~((last_q << 1) - one_lp);
  assign hi_req  = v_i & hi_mask;

  // Rotated winner: lowest set bit above last_q, else lowest set bit overall.
  always_comb begin
    rr_pick = '0;
    if (|hi_req) begin
      rr_pick = hi_req & (~hi_req + one_lp);
    end else begin
      rr_pick = v_i & (~v_i + one_lp);
    end
  end

`ifdef BSG_ARB_RR_LOCK_EN
  // A locked, still-requesting previous winner overrides rotation; since it is
  // already last_q, priority does not advance while locked.
  assign pick = (lock_i && |(v_i & last_q)) ? last_q : rr_pick;
`else
  assign pick = rr_pick;
`endif

  assign grant         = accept ? pick : '0;
  assign yumi_o        = grant;
  assign sel_one_hot_o = grant;

  // One-hot mux: gate each word by its grant bit, then OR them together.
  for (genvar gi = 0; gi < els_p; gi++) begin : g_mux
    assign masked_words[gi] = data_i[gi*width_p +: width_p] & {width_p{grant[gi]}};
  end

  // OR-reduce the gated words into the selected word.
  always_comb begin
    data_sel = '0;
    for (int k = 0; k < els_p; k++) begin
      data_sel = data_sel | masked_words[k];
    end
  end

  // Next-state: load on accept, empty on a drain without refill, else hold.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    tag_d  = tag_q;
    last_d = last_q;
    if (accept) begin
      v_d    = 1'b1;
      data_d = data_sel;
      tag_d  = grant;
      last_d = grant;
    end else if (v_q && ready_i) begin
      v_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset; requester 0 starts highest.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
      last_q <= one_lp << (els_p - 1);
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      tag_q  <= tag_d;
      last_q <= last_d;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;
  assign tag_o  = tag_q;

endmodule
